// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer for the playfield row store: scans bottom-up, drops full
// rows, compacts the rest downward, zero-fills the top and tallies cleared lines.
module line_clear_ctrl #(
  parameter int unsigned GRID_WIDTH  = 10,
  parameter int unsigned GRID_HEIGHT = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [4:0]            rd_addr,
  input  logic [GRID_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [GRID_WIDTH-1:0] wr_data,
  output logic [4:0]            lines_cleared,
  output logic [15:0]           total_lines
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 5;
  localparam int unsigned TW = 16;
  localparam int unsigned SW = TW + 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(GRID_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EVAL,
    FILL,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] rptr, rptr_nxt;
  logic [AW-1:0] wptr, wptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] lines_nxt;
  logic [TW-1:0] total_nxt;
  logic          row_full;
  logic [SW-1:0] total_sum;

  assign row_full  = &rd_data;
  assign total_sum = SW'(total_lines) + SW'(cnt);

  // State and bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rptr          <= '0;
      wptr          <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
    end else begin
      state         <= state_nxt;
      rptr          <= rptr_nxt;
      wptr          <= wptr_nxt;
      cnt           <= cnt_nxt;
      lines_cleared <= lines_nxt;
      total_lines   <= total_nxt;
    end
  end

  // Next-state and strobe decode; EVAL forwards the just-read row straight to the write port
  always_comb begin
    state_nxt = state;
    rptr_nxt  = rptr;
    wptr_nxt  = wptr;
    cnt_nxt   = cnt;
    lines_nxt = lines_cleared;
    total_nxt = total_lines;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    case (state)
      IDLE: begin
        if (start) begin
          rptr_nxt  = LAST_ROW;
          wptr_nxt  = LAST_ROW;
          cnt_nxt   = '0;
          state_nxt = RD;
        end
      end

      RD: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = rptr;
        state_nxt = EVAL;
      end

      EVAL: begin
        busy = 1'b1;
        if (row_full) begin
          cnt_nxt = cnt + CW'(1);
        end else begin
          if (rptr != wptr) begin
            wr_en   = 1'b1;
            wr_addr = wptr;
            wr_data = rd_data;
          end
          // wptr >= rptr always, so it only sits at 0 on the final row with nothing cleared
          if (wptr != '0) begin
            wptr_nxt = wptr - AW'(1);
          end
        end
        if (rptr == '0) begin
          state_nxt = (cnt_nxt != '0) ? FILL : DONE;
        end else begin
          rptr_nxt  = rptr - AW'(1);
          state_nxt = RD;
        end
      end

      FILL: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = wptr;
        wr_data = '0;
        if (wptr == '0) begin
          state_nxt = DONE;
        end else begin
          wptr_nxt = wptr - AW'(1);
        end
      end

      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        lines_nxt = cnt;
        total_nxt = total_sum[TW] ? {TW{1'b1}} : total_sum[TW-1:0];
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: behavioural row-store model plus a
// compaction reference computed directly from the playfield contents.
module tb_line_clear_ctrl;

  localparam int W = 10;
  localparam int H = 20;
  localparam logic [W-1:0] FULL = {W{1'b1}};

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         busy, done, rd_en, wr_en;
  logic [4:0]   rd_addr, wr_addr;
  logic [W-1:0] rd_data = '0;
  logic [W-1:0] wr_data;
  logic [4:0]   lines_cleared;
  logic [15:0]  total_lines;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  line_clear_ctrl #(.GRID_WIDTH(W), .GRID_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lines_cleared(lines_cleared), .total_lines(total_lines)
  );

  // Synchronous row store with a bulk preload port, plus a bus monitor
  logic [W-1:0] mem [H];
  logic [W-1:0] pre [H];
  logic         load = 1'b0;
  int           rd_total = 0;
  int           ovl_total = 0;
  int           log_addr[$];
  logic [W-1:0] log_data[$];

  always @(posedge clock) begin
    if (load) begin
      mem <= pre;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
    if (rd_en) rd_total <= rd_total + 1;
    if (rd_en && wr_en) ovl_total <= ovl_total + 1;
    if (wr_en) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(wr_data);
    end
  end

  // Reference: expected final playfield, write sequence and line count
  logic [W-1:0] exp_mem [H];
  int           exp_wa[$];
  logic [W-1:0] exp_wd[$];
  int           exp_cnt;
  int           exp_total = 0;

  function automatic void build_model();
    int k;
    k = 0;
    exp_cnt = 0;
    exp_wa.delete();
    exp_wd.delete();
    for (int a = 0; a < H; a++) exp_mem[a] = '0;
    for (int r = H - 1; r >= 0; r--) begin
      if (pre[r] == FULL) begin
        exp_cnt++;
      end else begin
        int dst;
        dst = H - 1 - k;
        exp_mem[dst] = pre[r];
        if (dst != r) begin
          exp_wa.push_back(dst);
          exp_wd.push_back(pre[r]);
        end
        k++;
      end
    end
    for (int a = exp_cnt - 1; a >= 0; a--) begin
      exp_wa.push_back(a);
      exp_wd.push_back('0);
    end
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    r = W'($urandom);
    if (r == FULL) r[0] = 1'b0;
    return r;
  endfunction

  // Loads pre[], runs one full pass and checks it against the reference
  task automatic run_pass(input string name, input int repulse_at);
    int rd0, ovl0, log0, busy_cycles, done_at, bad, nwr;
    build_model();
    @(negedge clock); load = 1'b1;
    @(negedge clock); load = 1'b0;
    rd0 = rd_total; ovl0 = ovl_total; log0 = log_addr.size();
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    busy_cycles = 0;
    done_at = -1;
    for (int c = 1; c <= 200 && done_at < 0; c++) begin
      if (busy) busy_cycles++;
      if (done) done_at = c;
      if (c == repulse_at) start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    exp_total = (exp_total + exp_cnt > 65535) ? 65535 : exp_total + exp_cnt;

    checks++;
    if (done_at < 0) begin
      errors++; $display("FAIL %s timeout: no done within 200 cycles", name);
    end
    checks++;
    if (done_at !== 2*H + exp_cnt + 1) begin
      errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_at, 2*H + exp_cnt + 1);
    end
    checks++;
    if (busy_cycles !== 2*H + exp_cnt + 1) begin
      errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_cycles, 2*H + exp_cnt + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after_done got %b exp 0", name, busy);
    end
    checks++;
    if (lines_cleared !== 5'(exp_cnt)) begin
      errors++; $display("FAIL %s lines_cleared got %0d exp %0d", name, lines_cleared, exp_cnt);
    end
    checks++;
    if (total_lines !== 16'(exp_total)) begin
      errors++; $display("FAIL %s total_lines got %0d exp %0d", name, total_lines, exp_total);
    end
    checks++;
    if (rd_total - rd0 !== H) begin
      errors++; $display("FAIL %s read_count got %0d exp %0d", name, rd_total - rd0, H);
    end
    checks++;
    if (ovl_total - ovl0 !== 0) begin
      errors++; $display("FAIL %s rd_wr_overlap got %0d exp 0", name, ovl_total - ovl0);
    end
    nwr = log_addr.size() - log0;
    checks++;
    if (nwr !== exp_wa.size()) begin
      errors++; $display("FAIL %s write_count got %0d exp %0d", name, nwr, exp_wa.size());
    end
    for (int i = 0; i < nwr && i < exp_wa.size(); i++) begin
      checks++;
      if (log_addr[log0 + i] !== exp_wa[i] || log_data[log0 + i] !== exp_wd[i]) begin
        errors++;
        $display("FAIL %s write[%0d] got addr %0d data %h exp addr %0d data %h",
                 name, i, log_addr[log0 + i], log_data[log0 + i], exp_wa[i], exp_wd[i]);
      end
    end
    bad = -1;
    for (int a = 0; a < H; a++) if (bad < 0 && mem[a] !== exp_mem[a]) bad = a;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL %s playfield row %0d got %h exp %h", name, bad, mem[bad], exp_mem[bad]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {busy, done, rd_en, wr_en});
    end
    checks++;
    if ({rd_addr, wr_addr, wr_data} !== '0) begin
      errors++; $display("FAIL reset_buses got %h/%h/%h exp 0", rd_addr, wr_addr, wr_data);
    end
    checks++;
    if (lines_cleared !== 5'd0 || total_lines !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", lines_cleared, total_lines);
    end
    exp_total = 0;
  endtask

  task automatic test_empty();
    for (int a = 0; a < H; a++) pre[a] = '0;
    run_pass("empty", 0);
  endtask

  task automatic test_single();
    for (int a = 0; a < H; a++) pre[a] = rand_row();
    pre[19] = FULL;
    pre[18] = 10'b0000000001;
    run_pass("single", 0);
  endtask

  task automatic test_tetris();
    for (int a = 0; a < H; a++) pre[a] = rand_row();
    for (int a = 16; a < 20; a++) pre[a] = FULL;
    pre[15] = 10'h155;
    run_pass("tetris", 0);
    checks++;
    if (mem[19] !== 10'h155) begin
      errors++; $display("FAIL tetris_bottom got %h exp 155", mem[19]);
    end
  endtask

  task automatic test_split();
    for (int a = 0; a < H; a++) pre[a] = rand_row();
    pre[19] = FULL; pre[17] = FULL;
    pre[18] = 10'h2AA; pre[16] = 10'h0F0;
    run_pass("split", 0);
    checks++;
    if (mem[19] !== 10'h2AA || mem[18] !== 10'h0F0) begin
      errors++; $display("FAIL split_rows got %h/%h exp 2aa/0f0", mem[19], mem[18]);
    end
  endtask

  task automatic test_all_full();
    for (int a = 0; a < H; a++) pre[a] = FULL;
    run_pass("all_full", 0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < H; a++) pre[a] = ($urandom_range(3) == 0) ? FULL : rand_row();
      run_pass("random", 0);
    end
  endtask

  task automatic test_restart_reset();
    for (int a = 0; a < H; a++) pre[a] = ($urandom_range(2) == 0) ? FULL : rand_row();
    run_pass("repulse", 10);
    for (int a = 0; a < H; a++) pre[a] = FULL;
    @(negedge clock); load = 1'b1;
    @(negedge clock); load = 1'b0;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b0) begin
      errors++; $display("FAIL pre_reset_eval got busy %b rd_en %b exp 1 0", busy, rd_en);
    end
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
      errors++; $display("FAIL midpass_reset_strobes got %b exp 0000", {busy, done, rd_en, wr_en});
    end
    checks++;
    if (lines_cleared !== 5'd0 || total_lines !== 16'd0) begin
      errors++; $display("FAIL midpass_reset_counts got %0d/%0d exp 0/0", lines_cleared, total_lines);
    end
    exp_total = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy got %b exp 0", busy);
    end
  endtask

  task automatic test_saturate();
    @(negedge clock);
    force dut.total_lines = 16'hFFFE;
    @(negedge clock);
    release dut.total_lines;
    @(negedge clock);
    checks++;
    if (total_lines !== 16'hFFFE) begin
      errors++; $display("FAIL preload_total got %h exp fffe", total_lines);
    end
    exp_total = 16'hFFFE;
    for (int a = 0; a < H; a++) pre[a] = rand_row();
    for (int a = 16; a < 20; a++) pre[a] = FULL;
    run_pass("saturate", 0);
    for (int a = 0; a < H; a++) pre[a] = rand_row();
    pre[10] = FULL;
    run_pass("saturate_hold", 0);
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    for (int a = 0; a < H; a++) pre[a] = '0;
    test_reset();
    test_empty();
    test_single();
    test_tetris();
    test_split();
    test_all_full();
    test_random();
    test_restart_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
